// File: rtl/st_bus_pkg.sv
// Shared types for the 68000 system bus arbiter.
// Holds the FSM encoding, owner width and the round-robin index helper.
package st_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GRANT,
    TURN
  } arb_state_t;

  localparam int OWNER_W     = 3;
  localparam int MAX_MASTERS = 8;

  function automatic logic [OWNER_W-1:0] rr_idx(
    input logic [OWNER_W-1:0] base,
    input int                 off,
    input int                 n
  );
    int v;
    v = (int'(base) + off) % n;
    return OWNER_W'(v);
  endfunction

endpackage

// File: rtl/st_bus_arbiter_rr_pick.sv
// Combinational round-robin picker over the sampled requests.
// Search starts just after the current owner, so the owner itself ranks last.
module rr_pick
  import st_bus_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]       req_s,
  input  logic [OWNER_W-1:0] owner,
  output logic               valid,
  output logic [OWNER_W-1:0] idx
);

  logic [OWNER_W-1:0] w_j;

  // Walk from farthest to nearest so the nearest hit is the one kept.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    w_j   = '0;
    for (int i = N; i >= 1; i--) begin
      w_j = rr_idx(owner, i, N);
      if (|(req_s & (N'(1) << w_j))) begin
        valid = 1'b1;
        idx   = w_j;
      end
    end
  end

endmodule

// File: rtl/st_bus_arbiter.sv
// 68000 bus arbiter: CPU BR/BG/BGACK handshake plus round-robin DMA grant.
// Inputs are sampled on phi1; all state and outputs move only on phi2.
module st_bus_arbiter
  import st_bus_pkg::*;
#(
  parameter int N        = 2,
  parameter int MAX_HOLD = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               phi1,
  input  logic               phi2,
  input  logic [N-1:0]       req,
  output logic [N-1:0]       gnt,
  output logic               preempt,
  output logic               cpu_br_n,
  input  logic               cpu_bg_n,
  input  logic               cpu_as_n,
  output logic               bgack_n,
  output logic [OWNER_W-1:0] owner
);

  localparam int            CW       = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

  arb_state_t         r_state;
  arb_state_t         w_state_n;
  logic               r_bg_s;
  logic               r_as_s;
  logic [N-1:0]       r_req_s;
  logic [OWNER_W-1:0] r_owner;
  logic [OWNER_W-1:0] w_owner_n;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      w_cnt_n;
  logic [CW-1:0]      w_cnt_inc;
  logic [N-1:0]       r_gnt;
  logic [N-1:0]       w_gnt_n;
  logic               r_preempt;
  logic               w_preempt_n;
  logic               r_br_n;
  logic               w_br_n_n;
  logic               r_bgack_n;
  logic               w_bgack_n_n;

  logic [N-1:0]       w_own_mask;
  logic               w_own_req;
  logic               w_others;
  logic               w_pick_v;
  logic [OWNER_W-1:0] w_pick_idx;

  rr_pick #(
    .N(N)
  ) u_pick (
    .req_s(r_req_s),
    .owner(r_owner),
    .valid(w_pick_v),
    .idx  (w_pick_idx)
  );

  assign w_own_mask = N'(1) << r_owner;
  assign w_own_req  = |(r_req_s & w_own_mask);
  assign w_others   = |(r_req_s & ~w_own_mask);
  assign w_cnt_inc  = (r_cnt == HOLD_MAX) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bg_s  <= 1'b1;
      r_as_s  <= 1'b1;
      r_req_s <= '0;
    end else if (phi1) begin
      r_bg_s  <= cpu_bg_n;
      r_as_s  <= cpu_as_n;
      r_req_s <= req;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else if (phi2) begin
      r_state <= w_state_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner   <= '0;
      r_cnt     <= '0;
      r_gnt     <= '0;
      r_preempt <= 1'b0;
      r_br_n    <= 1'b1;
      r_bgack_n <= 1'b1;
    end else if (phi2) begin
      r_owner   <= w_owner_n;
      r_cnt     <= w_cnt_n;
      r_gnt     <= w_gnt_n;
      r_preempt <= w_preempt_n;
      r_br_n    <= w_br_n_n;
      r_bgack_n <= w_bgack_n_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_owner_n   = r_owner;
    w_cnt_n     = r_cnt;
    w_gnt_n     = r_gnt;
    w_preempt_n = r_preempt;
    w_br_n_n    = r_br_n;
    w_bgack_n_n = r_bgack_n;
    unique case (r_state)
      IDLE: begin
        if (w_pick_v) begin
          w_owner_n = w_pick_idx;
          w_br_n_n  = 1'b0;
          w_state_n = REQ;
        end
      end
      REQ: begin
        if (!w_own_req) begin
          if (w_pick_v) begin
            w_owner_n = w_pick_idx;
          end else begin
            w_br_n_n  = 1'b1;
            w_state_n = IDLE;
          end
        // as_s low means a CPU cycle is still on the bus
        end else if (!r_bg_s && r_as_s) begin
          w_bgack_n_n = 1'b0;
          w_gnt_n     = w_own_mask;
          w_br_n_n    = 1'b1;
          w_cnt_n     = '0;
          w_state_n   = GRANT;
        end
      end
      GRANT: begin
        if (!w_own_req) begin
          w_gnt_n     = '0;
          w_preempt_n = 1'b0;
          w_state_n   = TURN;
        end else begin
          w_cnt_n     = w_cnt_inc;
          w_preempt_n = (w_cnt_inc == HOLD_MAX) && w_others;
        end
      end
      TURN: begin
        if (w_pick_v) begin
          w_owner_n   = w_pick_idx;
          w_gnt_n     = N'(1) << w_pick_idx;
          w_cnt_n     = '0;
          w_preempt_n = 1'b0;
          w_state_n   = GRANT;
        end else begin
          w_bgack_n_n = 1'b1;
          w_state_n   = IDLE;
        end
      end
      default: begin
        w_state_n = IDLE;
      end
    endcase
  end

  assign gnt      = r_gnt;
  assign preempt  = r_preempt;
  assign cpu_br_n = r_br_n;
  assign bgack_n  = r_bgack_n;
  assign owner    = r_owner;

endmodule

// File: tb/tb_st_bus_arbiter.sv
// Self-checking bench for st_bus_arbiter with N=2, MAX_HOLD=4.
// Vector table plus a scoreboard queue, and a hand sequence for async reset.
module tb_st_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       phi1 = 1'b0;
  logic       phi2 = 1'b0;
  logic [1:0] req = '0;
  logic [1:0] gnt;
  logic       preempt;
  logic       cpu_br_n;
  logic       cpu_bg_n = 1'b1;
  logic       cpu_as_n = 1'b1;
  logic       bgack_n;
  logic [2:0] owner;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0] gnt;
    logic       pre;
    logic       br_n;
    logic       bgack_n;
    logic [2:0] own;
  } out_t;

  typedef struct {
    string      nm;
    logic [1:0] req;
    logic       bg_n;
    logic       as_n;
    out_t       exp;
  } vec_t;

  vec_t tbl[$];
  out_t sb[$];

  st_bus_arbiter #(
    .N(2),
    .MAX_HOLD(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .phi1(phi1),
    .phi2(phi2),
    .req(req),
    .gnt(gnt),
    .preempt(preempt),
    .cpu_br_n(cpu_br_n),
    .cpu_bg_n(cpu_bg_n),
    .cpu_as_n(cpu_as_n),
    .bgack_n(bgack_n),
    .owner(owner)
  );

  always #5 clk = ~clk;

  function automatic out_t cur();
    out_t o;
    o = {gnt, preempt, cpu_br_n, bgack_n, owner};
    return o;
  endfunction

  function automatic void add(string nm, logic [1:0] r, logic bg, logic as_,
                              logic [1:0] g, logic p, logic br, logic ba,
                              logic [2:0] o);
    vec_t v;
    v.nm = nm;
    v.req = r;
    v.bg_n = bg;
    v.as_n = as_;
    v.exp = {g, p, br, ba, o};
    tbl.push_back(v);
  endfunction

  task automatic chk(string nm, out_t got, out_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got gnt=%b pre=%b br_n=%b bgack_n=%b own=%0d want gnt=%b pre=%b br_n=%b bgack_n=%b own=%0d",
               nm, got.gnt, got.pre, got.br_n, got.bgack_n, got.own,
               exp.gnt, exp.pre, exp.br_n, exp.bgack_n, exp.own);
    end
  endtask

  task automatic inv(string nm);
    total++;
    if (!$onehot0(gnt) || (gnt != 2'b00 && bgack_n !== 1'b0)) begin
      bad++;
      $display("FAIL inv_%s got gnt=%b bgack_n=%b want onehot0 gnt with bgack_n=0",
               nm, gnt, bgack_n);
    end
  endtask

  task automatic step();
    @(negedge clk); phi1 = 1'b1;
    @(negedge clk); phi1 = 1'b0;
    @(negedge clk); phi2 = 1'b1;
    @(negedge clk); phi2 = 1'b0;
  endtask

  task automatic apply(string nm, logic [1:0] r, logic bg, logic as_, out_t exp);
    out_t e;
    req = r;
    cpu_bg_n = bg;
    cpu_as_n = as_;
    sb.push_back(exp);
    step();
    e = sb.pop_front();
    chk(nm, cur(), e);
    inv(nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    //        name        req  bg  as   gnt  pre br ba own
    add("t1_br",     2'b01, 1, 1, 2'b00, 0, 0, 1, 0);
    add("t2_as0a",   2'b01, 0, 0, 2'b00, 0, 0, 1, 0);
    add("t2_as0b",   2'b01, 0, 0, 2'b00, 0, 0, 1, 0);
    add("t2_as0c",   2'b01, 0, 0, 2'b00, 0, 0, 1, 0);
    add("t1_gnt",    2'b01, 0, 1, 2'b01, 0, 1, 0, 0);
    add("rel_turn",  2'b00, 1, 1, 2'b00, 0, 1, 0, 0);
    add("rel_idle",  2'b00, 1, 1, 2'b00, 0, 1, 1, 0);
    add("t3_br",     2'b11, 1, 1, 2'b00, 0, 0, 1, 1);
    add("t3_gnt",    2'b11, 0, 1, 2'b10, 0, 1, 0, 1);
    add("t3_hold",   2'b11, 0, 1, 2'b10, 0, 1, 0, 1);
    add("t3_turn",   2'b01, 0, 1, 2'b00, 0, 1, 0, 1);
    add("t3_next",   2'b01, 0, 1, 2'b01, 0, 1, 0, 0);
    add("t4_c1",     2'b11, 0, 1, 2'b01, 0, 1, 0, 0);
    add("t4_c2",     2'b11, 0, 1, 2'b01, 0, 1, 0, 0);
    add("t4_c3",     2'b11, 0, 1, 2'b01, 0, 1, 0, 0);
    add("t4_pre",    2'b11, 0, 1, 2'b01, 1, 1, 0, 0);
    add("t4_sat",    2'b11, 0, 1, 2'b01, 1, 1, 0, 0);
    add("t4_drop",   2'b10, 0, 1, 2'b00, 0, 1, 0, 0);
    add("t4_next",   2'b10, 0, 1, 2'b10, 0, 1, 0, 1);
    add("re_turn",   2'b00, 0, 1, 2'b00, 0, 1, 0, 1);
    add("re_last",   2'b10, 0, 1, 2'b10, 0, 1, 0, 1);
    add("re_rel",    2'b00, 0, 1, 2'b00, 0, 1, 0, 1);
    add("re_idle",   2'b00, 1, 1, 2'b00, 0, 1, 1, 1);
    add("t5_br",     2'b01, 1, 1, 2'b00, 0, 0, 1, 0);
    add("t5_drop",   2'b00, 1, 1, 2'b00, 0, 1, 1, 0);
    add("t5_bg",     2'b00, 0, 1, 2'b00, 0, 1, 1, 0);
    add("rt_br",     2'b01, 1, 1, 2'b00, 0, 0, 1, 0);
    add("rt_sw",     2'b10, 1, 1, 2'b00, 0, 0, 1, 1);
    add("rt_gnt",    2'b10, 0, 1, 2'b10, 0, 1, 0, 1);
    add("rt_rel",    2'b00, 1, 1, 2'b00, 0, 1, 0, 1);
    add("rt_idle",   2'b00, 1, 1, 2'b00, 0, 1, 1, 1);

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset", cur(), {2'b00, 1'b0, 1'b1, 1'b1, 3'd0});

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].nm, tbl[i].req, tbl[i].bg_n, tbl[i].as_n, tbl[i].exp);
    end

    apply("t6_br",  2'b01, 1, 1, {2'b00, 1'b0, 1'b0, 1'b1, 3'd0});
    apply("t6_gnt", 2'b01, 0, 1, {2'b01, 1'b0, 1'b1, 1'b0, 3'd0});
    @(posedge clk);
    #2 reset = 1'b1;
    #1 chk("t6_async", cur(), {2'b00, 1'b0, 1'b1, 1'b1, 3'd0});
    @(negedge clk);
    reset = 1'b0;
    apply("t6_after", 2'b00, 1, 1, {2'b00, 1'b0, 1'b1, 1'b1, 3'd0});

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_empty got %0d entries want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
